uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 121 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frames start/data/parity/stop bits from an oversampled line
// using a majority-voted sample supplied by an external data sampler.
module uart_rx_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] prescale,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic       sampled_bit,
  output logic       data_samp_en,
  output logic [4:0] edge_cnt,
  output logic [7:0] P_DATA,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] bit_cnt;
  logic [5:0] pre_lat;
  logic       par_en_lat;
  logic       par_typ_lat;
  logic       bit_end;

  // Frame configuration is latched at the start edge, so mid-frame input changes are ignored
  assign bit_end = ({1'b0, edge_cnt} == (pre_lat - 6'd1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    data_samp_en = 1'b1;
    case (state)
      IDLE: begin
        data_samp_en = 1'b0;
        if (!RX_IN) begin
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = sampled_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end && (bit_cnt == 3'd7)) begin
          state_nxt = par_en_lat ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Parity is checked against the fully assembled byte; the stop bit gates data_valid
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt    <= 5'd0;
      bit_cnt     <= 3'd0;
      pre_lat     <= 6'd0;
      par_en_lat  <= 1'b0;
      par_typ_lat <= 1'b0;
      P_DATA      <= 8'h00;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (state == IDLE) begin
        edge_cnt <= 5'd0;
        if (!RX_IN) begin
          bit_cnt     <= 3'd0;
          pre_lat     <= prescale;
          par_en_lat  <= PAR_EN;
          par_typ_lat <= PAR_TYP;
          par_err     <= 1'b0;
          stp_err     <= 1'b0;
        end
      end else begin
        edge_cnt <= bit_end ? 5'd0 : edge_cnt + 5'd1;
        if (bit_end) begin
          case (state)
            DATA: begin
              P_DATA  <= {sampled_bit, P_DATA[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
            PARITY: begin
              par_err <= sampled_bit ^ (^P_DATA) ^ par_typ_lat;
            end
            STOP: begin
              stp_err    <= ~sampled_bit;
              data_valid <= sampled_bit & ~par_err;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frames plus randomized frames checked
// against a frame-level model of the receiver's outcome.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       sampled_bit = 1'b1;
  logic       data_samp_en;
  logic [4:0] edge_cnt;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic       rx_prev = 1'b1;
  logic [7:0] dv_data[$];
  int         dv_cyc[$];

  uart_rx_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescale(prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit), .data_samp_en(data_samp_en),
    .edge_cnt(edge_cnt), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  // The sampler output trails the line by one cycle, matching the cycle spent detecting the start edge
  task automatic tick(input logic rx);
    sampled_bit = rx_prev;
    RX_IN       = rx;
    rx_prev     = rx;
    @(negedge CLK);
    cyc++;
    if (data_valid === 1'b1) begin
      dv_data.push_back(P_DATA);
      dv_cyc.push_back(cyc);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                               input logic pbit, input logic sbit, input logic scramble,
                               output int start_cyc);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(sbit);
    prescale  = 6'(p);
    PAR_EN    = pen;
    PAR_TYP   = ptyp;
    start_cyc = cyc;
    foreach (bits[b]) begin
      for (int c = 0; c < p; c++) begin
        tick(bits[b]);
        if (scramble) begin
          case ($urandom_range(0, 2))
            0:       prescale = 6'd8;
            1:       prescale = 6'd16;
            default: prescale = 6'd32;
          endcase
          PAR_EN  = 1'($urandom);
          PAR_TYP = 1'($urandom);
        end
      end
    end
    tick(1'b1);
  endtask

  function automatic void model(input logic [7:0] d, input logic pen, input logic ptyp,
                                input logic pbit, input logic sbit,
                                output logic v, output logic perr, output logic serr);
    logic good_par;
    good_par = ptyp ? ~(^d) : ^d;
    perr = pen && (pbit != good_par);
    serr = !sbit;
    v    = sbit && !perr;
  endfunction

  task automatic test_reset();
    n_tests++; if (data_samp_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_samp_en: got %b want 0", data_samp_en); end
    n_tests++; if (edge_cnt !== 5'd0) begin n_fail++; $display("[TB] FAIL rst_edge_cnt: got %0d want 0", edge_cnt); end
    n_tests++; if (P_DATA !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_p_data: got %h want 00", P_DATA); end
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_data_valid: got %b want 0", data_valid); end
    n_tests++; if ({par_err, stp_err} !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_flags: got %b want 00", {par_err, stp_err}); end
    RX_IN = 1'b1;
    rx_prev = 1'b1;
    RST = 1'b1;
    repeat (4) tick(1'b1);
    n_tests++; if (data_samp_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_idle_wait: got %b want 0", data_samp_en); end
  endtask

  task automatic test_no_parity();
    int s;
    dv_data.delete(); dv_cyc.delete();
    applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
    tick(1'b1);
    n_tests++; if (dv_data.size() !== 1) begin n_fail++; $display("[TB] FAIL nopar_pulses: got %0d want 1", dv_data.size()); end
    else begin
      n_tests++; if (dv_data[0] !== 8'hA5) begin n_fail++; $display("[TB] FAIL nopar_data: got %h want a5", dv_data[0]); end
      n_tests++; if (dv_cyc[0] - s !== 81) begin n_fail++; $display("[TB] FAIL nopar_latency: got %0d want 81", dv_cyc[0] - s); end
    end
    n_tests++; if ({par_err, stp_err} !== 2'b00) begin n_fail++; $display("[TB] FAIL nopar_flags: got %b want 00", {par_err, stp_err}); end
  endtask

  task automatic test_even_parity();
    int s;
    dv_data.delete(); dv_cyc.delete();
    applyStimulus(8'h03, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, s);
    tick(1'b1);
    n_tests++; if (dv_data.size() !== 1) begin n_fail++; $display("[TB] FAIL evenpar_pulses: got %0d want 1", dv_data.size()); end
    else begin
      n_tests++; if (dv_cyc[0] - s !== 177) begin n_fail++; $display("[TB] FAIL evenpar_latency: got %0d want 177", dv_cyc[0] - s); end
    end
    n_tests++; if (par_err !== 1'b0) begin n_fail++; $display("[TB] FAIL evenpar_ok_err: got %b want 0", par_err); end
    dv_data.delete(); dv_cyc.delete();
    applyStimulus(8'h03, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, s);
    tick(1'b1);
    n_tests++; if (par_err !== 1'b1) begin n_fail++; $display("[TB] FAIL evenpar_bad_err: got %b want 1", par_err); end
    n_tests++; if (dv_data.size() !== 0) begin n_fail++; $display("[TB] FAIL evenpar_bad_pulses: got %0d want 0", dv_data.size()); end
    n_tests++; if (P_DATA !== 8'h03) begin n_fail++; $display("[TB] FAIL evenpar_bad_data: got %h want 03", P_DATA); end
  endtask

  task automatic test_stop_err();
    int s;
    dv_data.delete(); dv_cyc.delete();
    applyStimulus(8'h00, 32, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, s);
    tick(1'b1);
    n_tests++; if (stp_err !== 1'b1) begin n_fail++; $display("[TB] FAIL stop_stp_err: got %b want 1", stp_err); end
    n_tests++; if (par_err !== 1'b0) begin n_fail++; $display("[TB] FAIL stop_par_err: got %b want 0", par_err); end
    n_tests++; if (dv_data.size() !== 0) begin n_fail++; $display("[TB] FAIL stop_pulses: got %0d want 0", dv_data.size()); end
  endtask

  task automatic test_back_to_back();
    int s1;
    int s2;
    dv_data.delete(); dv_cyc.delete();
    applyStimulus(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s1);
    applyStimulus(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s2);
    tick(1'b1);
    tick(1'b1);
    n_tests++; if (dv_data.size() !== 2) begin n_fail++; $display("[TB] FAIL b2b_pulses: got %0d want 2", dv_data.size()); end
    else begin
      n_tests++; if (dv_data[0] !== 8'h5A) begin n_fail++; $display("[TB] FAIL b2b_first: got %h want 5a", dv_data[0]); end
      n_tests++; if (dv_data[1] !== 8'hC3) begin n_fail++; $display("[TB] FAIL b2b_second: got %h want c3", dv_data[1]); end
      n_tests++; if (dv_cyc[1] - s2 !== 81) begin n_fail++; $display("[TB] FAIL b2b_latency: got %0d want 81", dv_cyc[1] - s2); end
    end
  endtask

  task automatic test_glitch();
    dv_data.delete(); dv_cyc.delete();
    prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) tick(1'b0);
    repeat (13) tick(1'b1);
    n_tests++; if (data_samp_en !== 1'b1) begin n_fail++; $display("[TB] FAIL glitch_in_start: got %b want 1", data_samp_en); end
    tick(1'b1);
    n_tests++; if (data_samp_en !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_back_idle: got %b want 0", data_samp_en); end
    repeat (20) tick(1'b1);
    n_tests++; if (dv_data.size() !== 0) begin n_fail++; $display("[TB] FAIL glitch_pulses: got %0d want 0", dv_data.size()); end
    n_tests++; if ({par_err, stp_err} !== 2'b00) begin n_fail++; $display("[TB] FAIL glitch_flags: got %b want 00", {par_err, stp_err}); end
    n_tests++; if (P_DATA !== 8'hC3) begin n_fail++; $display("[TB] FAIL glitch_p_data: got %h want c3", P_DATA); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    int         s;
    d = 8'h6C;
    dv_data.delete(); dv_cyc.delete();
    prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    for (int t = 0; t <= 36; t++) begin
      if (t < 8) tick(1'b0);
      else tick(d[(t / 8) - 1]);
    end
    n_tests++; if (edge_cnt !== 5'd4) begin n_fail++; $display("[TB] FAIL midrst_pre_edge: got %0d want 4", edge_cnt); end
    #1 RST = 1'b0;
    #1;
    n_tests++; if ({data_samp_en, data_valid, par_err, stp_err} !== 4'b0000) begin n_fail++; $display("[TB] FAIL midrst_flags: got %b want 0000", {data_samp_en, data_valid, par_err, stp_err}); end
    n_tests++; if (edge_cnt !== 5'd0) begin n_fail++; $display("[TB] FAIL midrst_edge: got %0d want 0", edge_cnt); end
    n_tests++; if (P_DATA !== 8'h00) begin n_fail++; $display("[TB] FAIL midrst_p_data: got %h want 00", P_DATA); end
    tick(1'b1);
    tick(1'b1);
    RST = 1'b1;
    repeat (40) tick(1'b1);
    n_tests++; if (dv_data.size() !== 0) begin n_fail++; $display("[TB] FAIL midrst_abort: got %0d pulses want 0", dv_data.size()); end
    n_tests++; if (data_samp_en !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_idle: got %b want 0", data_samp_en); end
    applyStimulus(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
    tick(1'b1);
    n_tests++; if (dv_data.size() !== 1) begin n_fail++; $display("[TB] FAIL midrst_next_pulses: got %0d want 1", dv_data.size()); end
    else begin
      n_tests++; if (dv_data[0] !== 8'h81) begin n_fail++; $display("[TB] FAIL midrst_next_data: got %h want 81", dv_data[0]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int         p;
    int         s;
    int         gap;
    logic       pen, ptyp, pbit, sbit, v, perr, serr;
    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      d    = 8'($urandom);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      pbit = ptyp ? ~(^d) : ^d;
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      sbit = ($urandom_range(0, 4) != 0);
      model(d, pen, ptyp, pbit, sbit, v, perr, serr);
      dv_data.delete(); dv_cyc.delete();
      applyStimulus(d, p, pen, ptyp, pbit, sbit, 1'b1, s);
      gap = $urandom_range(1, 3);
      repeat (gap) tick(1'b1);
      n_tests++; if (dv_data.size() !== int'(v)) begin n_fail++; $display("[TB] FAIL rand%0d_pulses: got %0d want %0d", n, dv_data.size(), v); end
      else if (v) begin
        n_tests++; if (dv_data[0] !== d) begin n_fail++; $display("[TB] FAIL rand%0d_data: got %h want %h", n, dv_data[0], d); end
        n_tests++; if (dv_cyc[0] - s !== (10 + int'(pen)) * p + 1) begin n_fail++; $display("[TB] FAIL rand%0d_latency: got %0d want %0d", n, dv_cyc[0] - s, (10 + int'(pen)) * p + 1); end
      end
      n_tests++; if (par_err !== perr) begin n_fail++; $display("[TB] FAIL rand%0d_par_err: got %b want %b", n, par_err, perr); end
      n_tests++; if (stp_err !== serr) begin n_fail++; $display("[TB] FAIL rand%0d_stp_err: got %b want %b", n, stp_err, serr); end
      n_tests++; if (P_DATA !== d) begin n_fail++; $display("[TB] FAIL rand%0d_p_data: got %h want %h", n, P_DATA, d); end
      n_tests++; if ({data_samp_en, edge_cnt} !== 6'd0) begin n_fail++; $display("[TB] FAIL rand%0d_idle: got %b want 000000", n, {data_samp_en, edge_cnt}); end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(negedge CLK);
    test_reset();
    test_no_parity();
    test_even_parity();
    test_stop_err();
    test_back_to_back();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
